// File: rtl/mem_access_unit_if.sv
// CPU-side load/store bus between the datapath and mem_access_unit.
// The master drives requests; the slave (the unit) accepts them and returns
// one completion pulse per accepted request.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end: turns byte-addressed byte/half/word requests into
// word accesses on a RAM without byte enables. Loads are lane-extracted and
// sign/zero extended; sub-word stores go through read-modify-write.
// Misaligned, illegal-size and out-of-range requests get an error response
// and never touch the RAM.
module mem_access_unit #(
  parameter int ADDR_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    bus,
  output logic                ram_wren,
  output logic [29:0]         ram_address,
  output logic [31:0]         ram_data,
  input  logic [31:0]         ram_q
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_ADDR = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;
  localparam logic [1:0] WR      = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  // One extra bit so a depth of 2^30 words does not wrap to zero.
  localparam logic [30:0] WORD_LIMIT = 31'(ADDR_WORDS);

  logic [1:0]  state;
  logic [29:0] addr_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic [31:0] data_q;

  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        accept;
  logic        req_err;
  logic [4:0]  lane_shift;
  logic [31:0] shifted_q;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign bus.req_ready  = (state == IDLE);
  assign accept         = bus.req_valid && (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  // Error decode on the live request: illegal size, misalignment, then range.
  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == SZ_BAD)
      req_err = 1'b1;
    else if (bus.req_size == SZ_HALF && bus.req_addr[0] != 1'b0)
      req_err = 1'b1;
    else if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    else if ({1'b0, bus.req_addr[31:2]} >= WORD_LIMIT)
      req_err = 1'b1;
  end

  // Little-endian lane extraction/extension for loads and lane merge for stores.
  // Alignment is already enforced, so one byte-granular shift serves both sizes.
  always_comb begin
    lane_shift = {lane_q, 3'b000};
    shifted_q  = ram_q >> lane_shift;
    load_val   = ram_q;
    lane_mask  = 32'h0000_0000;
    case (size_q)
      SZ_BYTE: begin
        load_val  = {{24{signed_q & shifted_q[7]}}, shifted_q[7:0]};
        lane_mask = 32'h0000_00FF << lane_shift;
      end
      SZ_HALF: begin
        load_val  = {{16{signed_q & shifted_q[15]}}, shifted_q[15:0]};
        lane_mask = 32'h0000_FFFF << lane_shift;
      end
      default: begin
        load_val  = ram_q;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    merged = (ram_q & ~lane_mask) | ((data_q << lane_shift) & lane_mask);
  end

  // Control FSM: errors stay idle, word stores write directly, everything else reads first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !req_err) begin
            if (bus.req_we && bus.req_size == SZ_WORD)
              state <= WR;
            else
              state <= RD_ADDR;
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: state <= we_q ? WR : IDLE;
        WR:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture on a good acceptance; the data register later holds the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      data_q   <= '0;
    end else if (accept && !req_err) begin
      addr_q   <= bus.req_addr[31:2];
      lane_q   <= bus.req_addr[1:0];
      size_q   <= bus.req_size;
      signed_q <= bus.req_signed;
      we_q     <= bus.req_we;
      data_q   <= bus.req_wdata;
    end else if (state == RD_DATA && we_q) begin
      data_q <= merged;
    end
  end

  // Completion pulse generation; rdata holds between pulses and is cleared for stores/errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      if (accept && req_err) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= 1'b1;
        resp_rdata_q <= '0;
      end else if (state == RD_DATA && !we_q) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= load_val;
      end else if (state == WR) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= '0;
      end
    end
  end

  assign ram_wren    = (state == WR);
  assign ram_address = addr_q;
  assign ram_data    = (state == WR) ? data_q : 32'h0000_0000;

endmodule
